cell_pixel_source: RTL
======================

Name: cell_pixel_source

Overview:
- Upstream pixel source for the VGA timing stage.
- Reads the Conway cell grid (1 bit per cell, double-banked block RAM) and expands each cell to a CELL_SIZE x CELL_SIZE square of pixels.
- Emits a continuous raster-order 640x480 12-bit RGB AXI-stream, buffered in a small prefetch FIFO so the sink never sees tvalid low while it is ready.
- Bank selection is latched per frame, so the life engine can write one bank while the other is displayed.

Parameters:
- H_ACTIVE, 640, active pixels per line; must equal GRID_W << CELL_SHIFT.
- V_ACTIVE, 480, active lines per frame; must equal GRID_H << CELL_SHIFT.
- CELL_SHIFT, 3, log2 of cell size in pixels (8x8 cells).
- GRID_W, 80, cells per row.
- GRID_H, 60, cell rows.
- CELL_ADDR_W, 13, address bits per bank; 2^CELL_ADDR_W >= GRID_W*GRID_H.
- FIFO_DEPTH, 4, pixel FIFO entries (power of 2, >= 2).
- ALIVE_COLOR, 12'hFFF, RGB for a live cell.
- DEAD_COLOR, 12'h000, RGB for a dead cell.
- GRID_COLOR, 12'h333, RGB for grid-line pixels.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable_strobe  in  1  pixel-rate qualifier shared with the VGA stage.
- bank_sel  in  1  bank to display; sampled at frame start.
- grid_enable  in  1  draw cell-boundary grid lines.
- cell_rd_en  out  1  cell RAM read enable.
- cell_addr  out  CELL_ADDR_W+1  {bank, cell index}.
- cell_rdata  in  1  cell RAM data; valid exactly 1 clk after cell_rd_en.
- pixel_tvalid  out  1  FIFO non-empty.
- pixel_tready  in  1  sink ready.
- pixel_tdata  out  12  {r[3:0], g[3:0], b[3:0]}.
- pixel_tuser  out  1  start of frame; set on pixel (0,0).
- pixel_tlast  out  1  end of line; set on x == H_ACTIVE-1.
- frame_start  out  1  1-clk pulse when pixel (0,0) is issued.
- active_bank  out  1  bank currently being read.

Behaviour:
- Reset values:
  - tvalid, tuser, tlast, tdata = 0.
  - cell_rd_en = 0, cell_addr = 0.
  - frame_start = 0, active_bank = 0.
  - x = y = 0; FIFO empty; in-flight flag cleared.
- Reset mid-frame discards FIFO contents and any in-flight read. The next frame restarts at (0,0). cell_rdata returning during or just after reset is ignored.
- Transfer (pop) occurs only when pixel_tvalid && pixel_tready && enable_strobe. tready without enable_strobe does not pop.
- Issue stage:
  - cell_rd_en = !reset && (fifo_count + inflight) < FIFO_DEPTH.
  - On issue, x/y advance: x wraps at H_ACTIVE-1 to 0 and y increments; at (H_ACTIVE-1, V_ACTIVE-1) both wrap to 0.
- Address and sideband generation:
  - cell_addr = {active_bank_next, (y>>CELL_SHIFT)*GRID_W + (x>>CELL_SHIFT)}. Maintain incrementally or multiply; result must be exact.
  - When issuing (0,0): active_bank <= bank_sel and frame_start pulses that cycle. The same bank applies to every read of that frame, including (0,0). bank_sel changes mid-frame have no effect until the next frame.
  - The grid flag, tuser and tlast for each pixel are computed at issue and carried 1 stage alongside the read. Grid flag = grid_enable && (x[CELL_SHIFT-1:0]==0 || y[CELL_SHIFT-1:0]==0), with grid_enable sampled at issue.
- Push stage (1 clk after issue), pixel colour:
  - GRID_COLOR if the grid flag is set;
  - else ALIVE_COLOR if cell_rdata = 1;
  - else DEAD_COLOR.
  - Push {tuser, tlast, colour} into the FIFO.
- FIFO:
  - Head is presented combinationally on pixel_tdata/tuser/tlast; stable while tvalid && !pop.
  - Simultaneous push and pop is legal at any occupancy, including full; count is unchanged.
  - The issue credit rule guarantees no overflow; pushing when full is a design error (assertion).
- Latency:
  - First issue in the 1st clk after reset deasserts.
  - Push on the next clk; tvalid high on the 3rd clk.
  - FIFO full within FIFO_DEPTH+2 clks.
- Throughput: sustained 1 pixel/clk, so no underflow with enable_strobe at any rate.
- Pixel order is strict raster; exactly H_ACTIVE*V_ACTIVE pixels per frame, tuser once per frame, tlast once per line.

Test Plan:
- Reset, tready=0: tvalid rises on the 3rd clk after reset falls. The FIFO fills to 4 with first beat tuser=1, tdata=DEAD_COLOR (RAM all 0, grid off). cell_rd_en drops after 4 issues.
- RAM cell (bank0, index 81) = 1, tready=1, enable_strobe every 4th clk: pixels x=8..15, lines 8..15 = 12'hFFF, all others 12'h000. tvalid never low while tready is high after the first beat.
- grid_enable=1: pixels with x%8==0 or y%8==0 = 12'h333 regardless of cell; others follow the RAM.
- bank_sel toggled at pixel (320,240): cell_addr MSB stays old bank until the next (0,0) issue. frame_start pulses once and active_bank updates there.
- Full frame count: exactly 307200 pops between tuser beats, 480 tlast beats, tlast on every x=639.
- Random tready/enable_strobe plus a reset asserted mid-line: FIFO empties and the next beat after recovery is (0,0) with tuser=1. Scoreboard matches the reference model throughout.

Source files
------------

// File: rtl/cell_pixel_source.sv
// Cell-grid pixel source: expands 1-bit Conway cells into a raster-order
// 12-bit RGB AXI-stream, double-banked per frame, via a small prefetch FIFO.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   enable_strobe     pixel-rate qualifier; a pop needs tvalid&tready&strobe
//   bank_sel          bank to display, latched when pixel (0,0) is issued
//   grid_enable       overlay cell-boundary grid lines (sampled at issue)
//   cell_rd_en/addr   cell RAM read port, addr = {bank, cell index}
//   cell_rdata        cell RAM data, valid one clock after cell_rd_en
//   pixel_t*          AXI-stream output (tuser = SOF, tlast = EOL)
//   frame_start       pulses on the cycle pixel (0,0) is issued
//   active_bank       bank being read for the current frame
`timescale 1ns/1ps

module cell_pixel_source #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          CELL_SHIFT  = 3,
    parameter int          GRID_W      = 80,
    parameter int          GRID_H      = 60,
    parameter int          CELL_ADDR_W = 13,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [11:0] ALIVE_COLOR = 12'hFFF,
    parameter logic [11:0] DEAD_COLOR  = 12'h000,
    parameter logic [11:0] GRID_COLOR  = 12'h333
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable_strobe,
    input  logic                   bank_sel,
    input  logic                   grid_enable,
    output logic                   cell_rd_en,
    output logic [CELL_ADDR_W:0]   cell_addr,
    input  logic                   cell_rdata,
    output logic                   pixel_tvalid,
    input  logic                   pixel_tready,
    output logic [11:0]            pixel_tdata,
    output logic                   pixel_tuser,
    output logic                   pixel_tlast,
    output logic                   frame_start,
    output logic                   active_bank
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = 14;

    // Issue-stage raster position and the cell index of the row start.
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [CELL_ADDR_W-1:0] row_base;
    logic                   at_origin;
    logic                   x_last;
    logic                   y_last;
    logic                   issue;
    logic                   bank_next;
    logic [CELL_ADDR_W-1:0] cell_index;

    // Sideband carried one stage alongside the RAM read.
    logic                   inflight;
    logic                   p_grid;
    logic                   p_user;
    logic                   p_last;

    // Prefetch FIFO.
    logic [FW-1:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [CW:0]            credit;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic [11:0]            colour;
    logic [FW-1:0]          head;

    assign at_origin  = (x == '0) && (y == '0);
    assign x_last     = (x == XW'(H_ACTIVE - 1));
    assign y_last     = (y == YW'(V_ACTIVE - 1));

    // Credit counts the read in flight so the FIFO can never overflow.
    assign credit     = {1'b0, count} + (CW+1)'(inflight);
    assign cell_rd_en = !reset && (credit < (CW+1)'(FIFO_DEPTH));
    assign issue      = cell_rd_en;

    // The (0,0) read already uses the newly selected bank.
    assign bank_next  = at_origin ? bank_sel : active_bank;
    assign cell_index = row_base + CELL_ADDR_W'(x >> CELL_SHIFT);
    assign cell_addr  = reset ? '0 : {bank_next, cell_index};
    assign frame_start = issue && at_origin;

    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            row_base    <= '0;
            active_bank <= 1'b0;
            inflight    <= 1'b0;
            p_grid      <= 1'b0;
            p_user      <= 1'b0;
            p_last      <= 1'b0;
            assert (H_ACTIVE == (GRID_W << CELL_SHIFT) &&
                    V_ACTIVE == (GRID_H << CELL_SHIFT) &&
                    (1 << CELL_ADDR_W) >= GRID_W * GRID_H);
        end else begin
            inflight <= issue;
            if (issue) begin
                p_grid <= grid_enable &&
                          (x[CELL_SHIFT-1:0] == '0 ||
                           y[CELL_SHIFT-1:0] == '0);
                p_user <= at_origin;
                p_last <= x_last;
                if (at_origin) begin
                    active_bank <= bank_sel;
                end
                if (x_last) begin
                    x <= '0;
                    if (y_last) begin
                        y        <= '0;
                        row_base <= '0;
                    end else begin
                        y <= y + 1'b1;
                        // Next line starts a new cell row.
                        if (&y[CELL_SHIFT-1:0]) begin
                            row_base <= row_base +
                                        CELL_ADDR_W'(GRID_W);
                        end
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    always_comb begin
        colour = DEAD_COLOR;
        if (p_grid) begin
            colour = GRID_COLOR;
        end else if (cell_rdata) begin
            colour = ALIVE_COLOR;
        end
    end

    assign push         = inflight;
    assign full         = (count == CW'(FIFO_DEPTH));
    assign pixel_tvalid = (count != '0);
    assign pop          = pixel_tvalid && pixel_tready && enable_strobe;
    assign head         = mem[rd_ptr];

    // Head is only driven while valid so idle outputs read as zero.
    assign pixel_tdata  = pixel_tvalid ? head[11:0] : 12'h000;
    assign pixel_tlast  = pixel_tvalid && head[12];
    assign pixel_tuser  = pixel_tvalid && head[13];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {p_user, p_last, colour};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && full && !pop));
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
